mem_bus_slave: RTL and testbench

- Parametrised memory slave on the shared multiplexed address/data bus (`uniBus`), replacing the fixed 8-bit memory model used by the core's fetch path.
- Each transaction has an address phase, optional wait states, then one or more data beats on the same bidirectional bus.
- Generalised in data width, address width, depth and wait states.
- Adds an address range error and, when configured, auto-incrementing bursts.

---
 rtl/mem_bus_slave.sv | 153 +++++++++++++++
 tb/tb_mem_bus_slave.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_slave.sv
// mem_bus_slave: word memory on a multiplexed address/data bus (address phase, wait states, data beats).
// Define MEM_BUS_BURST_EN to honour burst_len (1-16 auto-incrementing beats); otherwise every access is one beat.
module mem_bus_slave #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req,
    input  logic              rd_nwr,
    input  logic [3:0]        burst_len,
    inout  wire  [DATA_W-1:0] uniBus,
    output logic              ready,
    output logic              busy,
    output logic              err
);
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]        LAST_WAIT = 4'(WAIT_CYCLES - 1);

    if (ADDR_W > DATA_W) begin : g_chk_addr_w
        $error("mem_bus_slave: ADDR_W (%0d) must not exceed DATA_W (%0d)", ADDR_W, DATA_W);
    end
    if (DEPTH > (2 ** ADDR_W)) begin : g_chk_depth
        $error("mem_bus_slave: DEPTH (%0d) exceeds the address space of ADDR_W (%0d)", DEPTH, ADDR_W);
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_chk_wait
        $error("mem_bus_slave: WAIT_CYCLES (%0d) must be within 0..15", WAIT_CYCLES);
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR
    } state_t;

    state_t            state;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wait_cnt;
    logic              last_beat;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] bus_addr;
    logic              bus_addr_bad;
    logic [ADDR_W-1:0] next_addr;
    logic [IDX_W-1:0]  idx;

    assign bus_addr     = uniBus[ADDR_W-1:0];
    assign bus_addr_bad = {1'b0, bus_addr} >= DEPTH_X;
    assign next_addr    = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    assign idx          = addr[IDX_W-1:0];

`ifdef MEM_BUS_BURST_EN
    logic [3:0] beats;
    assign last_beat = (beats == 4'd0);
`else
    // Without bursts every transaction ends after its first beat.
    logic unused_burst_len;
    assign unused_burst_len = ^burst_len;
    assign last_beat        = 1'b1;
`endif

    // Read data is driven only during read DATA cycles; reset clears state asynchronously and so releases the bus.
    assign uniBus = (state == S_DATA && rd) ? mem[idx] : {DATA_W{1'bz}};

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            rd       <= 1'b0;
            addr     <= '0;
            wait_cnt <= '0;
`ifdef MEM_BUS_BURST_EN
            beats    <= '0;
`endif
            ready    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        rd       <= rd_nwr;
                        addr     <= bus_addr;
                        wait_cnt <= '0;
`ifdef MEM_BUS_BURST_EN
                        beats    <= burst_len;
`endif
                        busy     <= 1'b1;
                        if (bus_addr_bad) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else if (WAIT_CYCLES > 0) begin
                            state <= S_WAIT;
                        end else begin
                            state <= S_DATA;
                            ready <= 1'b1;
                        end
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        state <= S_DATA;
                        ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    addr <= next_addr;
                    if (last_beat) begin
                        state <= S_IDLE;
                        ready <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
`ifdef MEM_BUS_BURST_EN
                        beats <= beats - 1'b1;
`endif
                    end
                end

                S_ERR: begin
                    state <= S_IDLE;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; its contents must survive RST.
    always_ff @(posedge CLK) begin
        if (state == S_DATA && !rd) begin
            mem[idx] <= uniBus;
        end
    end

endmodule

// File: tb/tb_mem_bus_slave.sv
// Bench for mem_bus_slave: instance a uses defaults, instance b uses DEPTH=128 and WAIT_CYCLES=2.
// Read data is predicted from a bench-side memory model and queued as each request is issued.
module tb_mem_bus_slave;
    localparam logic [7:0] PULL = 8'hff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, rst_n_b;
    logic       sel;
    logic       req, rd_nwr, bus_oe;
    logic [3:0] burst_len;
    logic [7:0] bus_drv;
    wire  [7:0] bus_a, bus_b;
    logic       ready_a, busy_a, err_a;
    logic       ready_b, busy_b, err_b;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_a [256];
    logic [7:0] model_b [128];
    logic [7:0] sb [$];

    assign bus_a = (bus_oe && !sel) ? bus_drv : 8'bz;
    assign bus_b = (bus_oe &&  sel) ? bus_drv : 8'bz;

    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup (bus_a[i]);
        pullup (bus_b[i]);
    end

    wire       ready_s = sel ? ready_b : ready_a;
    wire       busy_s  = sel ? busy_b  : busy_a;
    wire       err_s   = sel ? err_b   : err_a;
    wire [7:0] bus_s   = sel ? bus_b   : bus_a;

    mem_bus_slave dut_a (
        .CLK       (clk),
        .RST       (rst_n_a),
        .req       (req & ~sel),
        .rd_nwr    (rd_nwr),
        .burst_len (burst_len),
        .uniBus    (bus_a),
        .ready     (ready_a),
        .busy      (busy_a),
        .err       (err_a)
    );

    mem_bus_slave #(.DEPTH(128), .WAIT_CYCLES(2)) dut_b (
        .CLK       (clk),
        .RST       (rst_n_b),
        .req       (req & sel),
        .rd_nwr    (rd_nwr),
        .burst_len (burst_len),
        .uniBus    (bus_b),
        .ready     (ready_b),
        .busy      (busy_b),
        .err       (err_b)
    );

    task automatic push_reads(input bit on_b, input logic [7:0] addr, input int n);
        for (int i = 0; i < n; i++) begin
            if (on_b) sb.push_back(model_b[(int'(addr) + i) % 128]);
            else      sb.push_back(model_a[(int'(addr) + i) % 256]);
        end
    endtask

    // One transaction on the selected instance; reads are checked against the queue beat by beat.
    task automatic run_txn(input string name, input logic is_rd, input logic [7:0] addr,
                           input logic [3:0] blen, input logic [7:0] wdata, input int exp_beats,
                           input int exp_lat, input int exp_errs, input bit quick);
        int         beats_seen;
        int         errs_seen;
        int         first;
        bit         done;
        logic [7:0] exp;
        beats_seen = 0;
        errs_seen  = 0;
        first      = -1;
        done       = 1'b0;
        if (!quick) begin
            @(posedge clk); #1;
        end
        req = 1'b1; rd_nwr = is_rd; burst_len = blen; bus_drv = addr; bus_oe = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        if (is_rd) bus_oe = 1'b0;
        else       bus_drv = wdata;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                checks++;
                if (busy_s !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy_after_req: got %b want 1", name, busy_s);
                end
            end
            if (err_s === 1'b1) errs_seen++;
            if (ready_s === 1'b1) begin
                if (first < 0) first = cyc;
                beats_seen++;
                if (is_rd) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL %s extra_beat: got data %h want no beat", name, bus_s);
                    end else begin
                        exp = sb.pop_front();
                        if (bus_s !== exp) begin
                            failures++;
                            $display("FAIL %s beat%0d_data: got %h want %h", name, beats_seen - 1, bus_s, exp);
                        end
                    end
                end
            end else if (is_rd) begin
                checks++;
                if (bus_s !== PULL) begin
                    failures++;
                    $display("FAIL %s bus_released_cyc%0d: got %h want %h", name, cyc, bus_s, PULL);
                end
            end
            if (busy_s !== 1'b1) done = 1'b1;
        end
        bus_oe = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: got busy still high want idle within 40 cycles", name);
        end
        checks++;
        if (beats_seen != exp_beats) begin
            failures++;
            $display("FAIL %s beat_count: got %0d want %0d", name, beats_seen, exp_beats);
        end
        checks++;
        if (errs_seen != exp_errs) begin
            failures++;
            $display("FAIL %s err_cycles: got %0d want %0d", name, errs_seen, exp_errs);
        end
        if (exp_beats > 0) begin
            checks++;
            if (first != exp_lat) begin
                failures++;
                $display("FAIL %s first_beat_cycle: got %0d want %0d", name, first, exp_lat);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s missing_beats: got %0d unread want 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        int bad;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            req = ~req; sel = i[0]; rd_nwr = 1'b1; bus_drv = 8'h01; bus_oe = 1'b0;
            @(negedge clk);
            checks++;
            if ({ready_a, busy_a, err_a, ready_b, busy_b, err_b} !== 6'b0) begin
                failures++;
                $display("FAIL reset_outputs: got %b want 000000",
                         {ready_a, busy_a, err_a, ready_b, busy_b, err_b});
            end
            checks++;
            if (bus_a !== PULL || bus_b !== PULL) begin
                failures++;
                $display("FAIL reset_bus: got %h/%h want %h/%h", bus_a, bus_b, PULL, PULL);
            end
        end
        req = 1'b0; sel = 1'b0;
        @(negedge clk);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 256; i++) if (dut_a.mem[i] !== model_a[i]) bad++;
        for (int i = 0; i < 128; i++) if (dut_b.mem[i] !== model_b[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_mem_kept: got %0d changed words want 0", bad);
        end
    endtask

    task automatic test_single_read();
        sel = 1'b0;
        push_reads(1'b0, 8'h01, 1);
        run_txn("single_read", 1'b1, 8'h01, 4'd0, 8'h00, 1, 0, 0, 1'b0);
    endtask

    task automatic test_write_read();
        sel = 1'b0;
        run_txn("write_ff", 1'b0, 8'hff, 4'd0, 8'haa, 1, 0, 0, 1'b0);
        model_a[255] = 8'haa;
        push_reads(1'b0, 8'hff, 1);
        run_txn("read_ff", 1'b1, 8'hff, 4'd0, 8'h00, 1, 0, 0, 1'b0);
        checks++;
        if (dut_a.mem[255] !== 8'haa) begin
            failures++;
            $display("FAIL write_mem_ff: got %h want aa", dut_a.mem[255]);
        end
    endtask

    task automatic test_burst_wrap();
        int n;
`ifdef MEM_BUS_BURST_EN
        n = 4;
`else
        n = 1;
`endif
        sel = 1'b0;
        push_reads(1'b0, 8'hfe, n);
        run_txn("burst_wrap", 1'b1, 8'hfe, 4'd3, 8'h00, n, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        run_txn("b2b_write", 1'b0, 8'h20, 4'd0, 8'h5c, 1, 0, 0, 1'b0);
        model_a[8'h20] = 8'h5c;
        push_reads(1'b0, 8'h20, 1);
        run_txn("b2b_read0", 1'b1, 8'h20, 4'd0, 8'h00, 1, 0, 0, 1'b1);
        push_reads(1'b0, 8'h21, 1);
        run_txn("b2b_read1", 1'b1, 8'h21, 4'd0, 8'h00, 1, 0, 0, 1'b1);
    endtask

    task automatic test_range_error();
        int bad;
        sel = 1'b1;
        run_txn("range_rd_80", 1'b1, 8'h80, 4'd0, 8'h00, 0, 0, 1, 1'b0);
        run_txn("range_wr_80", 1'b0, 8'h80, 4'd0, 8'h3c, 0, 0, 1, 1'b0);
        run_txn("range_rd_ff", 1'b1, 8'hff, 4'd0, 8'h00, 0, 0, 1, 1'b0);
        bad = 0;
        for (int i = 0; i < 128; i++) if (dut_b.mem[i] !== model_b[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL range_mem_kept: got %0d changed words want 0", bad);
        end
        push_reads(1'b1, 8'h7f, 1);
        run_txn("range_rd_7f", 1'b1, 8'h7f, 4'd0, 8'h00, 1, 2, 0, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        logic [7:0] wdata;
        sel   = 1'b1;
        wdata = ~model_b[16];
        @(posedge clk); #1;
        req = 1'b1; rd_nwr = 1'b0; burst_len = 4'd0; bus_drv = 8'h10; bus_oe = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; bus_drv = wdata;
        @(posedge clk); #2;
        rst_n_b = 1'b0;
        #1;
        checks++;
        if ({ready_b, busy_b, err_b} !== 3'b000) begin
            failures++;
            $display("FAIL midwait_reset_outputs: got %b want 000", {ready_b, busy_b, err_b});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus_oe = 1'b0;
        #1;
        checks++;
        if (bus_b !== PULL) begin
            failures++;
            $display("FAIL midwait_bus: got %h want %h", bus_b, PULL);
        end
        @(negedge clk);
        rst_n_b = 1'b1;
        checks++;
        if (dut_b.mem[16] !== model_b[16]) begin
            failures++;
            $display("FAIL midwait_mem_kept: got %h want %h", dut_b.mem[16], model_b[16]);
        end
        push_reads(1'b1, 8'h10, 1);
        run_txn("after_reset_rd", 1'b1, 8'h10, 4'd0, 8'h00, 1, 2, 0, 1'b0);
        run_txn("after_reset_wr", 1'b0, 8'h10, 4'd0, wdata, 1, 2, 0, 1'b0);
        model_b[16] = wdata;
        push_reads(1'b1, 8'h10, 1);
        run_txn("after_reset_rd2", 1'b1, 8'h10, 4'd0, 8'h00, 1, 2, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        sel = 1'b0; req = 1'b0; rd_nwr = 1'b1; burst_len = 4'd0; bus_drv = 8'h00; bus_oe = 1'b0;
        #1;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        for (int i = 0; i < 256; i++) model_a[i] = 8'($urandom);
        for (int i = 0; i < 4; i++)   model_a[i] = 8'(8'h10 + i);
        for (int i = 0; i < 128; i++) model_b[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) dut_a.mem[i] = model_a[i];
        for (int i = 0; i < 128; i++) dut_b.mem[i] = model_b[i];

        test_reset();
        test_single_read();
        test_write_read();
        test_burst_wrap();
        test_back_to_back();
        test_range_error();
        test_reset_mid_wait();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
